alu_control_md: RTL and testbench

- Parametrised successor to the single-cycle ALU control decoder for the MIPS datapath.
- Decodes ALUOp/Func into the 4-bit ALU select for single-cycle ops, same code map as today.
- Adds an iterative multi-cycle engine for mult/div/mod, with a stall handshake that freezes PC/pipeline registers until the result is ready.
- Sits between the main control unit, the register file read ports and the ALU/writeback mux.

---
 rtl/alu_ctrl_pkg.sv | 75 +++++++
 rtl/alu_control_md_muldiv_iter.sv | 101 ++++++++++
 rtl/alu_control_md.sv | 207 ++++++++++++++++++++
 tb/tb_alu_control_md.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared decode constants for the MIPS ALU control decoder and its
// multi-cycle mult/div/mod engine:
//   - ALU select codes driven onto alu_sel
//   - ALUOp codes from the main control unit
//   - funct field codes for R-type instructions
//   - state encoding of the mult/div handshake FSM
//   - a helper that turns ALUOp/funct into an ALU select
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MULT = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_MOD  = 4'd8;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_RSVD = 2'b11;

  localparam logic [5:0] FUNC_ADD  = 6'd0;
  localparam logic [5:0] FUNC_SUB  = 6'd2;
  localparam logic [5:0] FUNC_AND  = 6'd4;
  localparam logic [5:0] FUNC_OR   = 6'd5;
  localparam logic [5:0] FUNC_XOR  = 6'd6;
  localparam logic [5:0] FUNC_MOD  = 6'd7;
  localparam logic [5:0] FUNC_MULT = 6'd8;
  localparam logic [5:0] FUNC_DIV  = 6'd26;
  localparam logic [5:0] FUNC_SLT  = 6'd42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  // Reserved ALUOp 11 and unknown funct codes fall back to add so a
  // malformed instruction never selects a multi-cycle operation.
  function automatic logic [3:0] decode_alu_sel(input logic [1:0] alu_op,
                                                input logic [5:0] func);
    logic [3:0] sel;
    sel = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:  sel = ALU_ADD;
      ALUOP_SUB:  sel = ALU_SUB;
      ALUOP_RSVD: sel = ALU_ADD;
      default: begin
        case (func)
          FUNC_ADD:  sel = ALU_ADD;
          FUNC_SUB:  sel = ALU_SUB;
          FUNC_MULT: sel = ALU_MULT;
          FUNC_DIV:  sel = ALU_DIV;
          FUNC_AND:  sel = ALU_AND;
          FUNC_OR:   sel = ALU_OR;
          FUNC_XOR:  sel = ALU_XOR;
          FUNC_SLT:  sel = ALU_SLT;
          FUNC_MOD:  sel = ALU_MOD;
          default:   sel = ALU_ADD;
        endcase
      end
    endcase
    return sel;
  endfunction

  function automatic logic is_md_sel(input logic [3:0] sel);
    return (sel == ALU_MULT) || (sel == ALU_DIV) || (sel == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_control_md_muldiv_iter.sv
// muldiv_iter
// Iterative unsigned engine: shift-add multiplier and restoring divider,
// one result bit per clock, DATA_W iterations per operation.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load a/b and begin (only pulsed while idle)
//   is_div       1: divide a by b, 0: multiply a by b
//   a, b         operands, sampled on start
//   busy         an operation is iterating
//   done         final iteration happens this cycle
//   lo, hi       result of the current iteration; the final result
//                (product low/high, or quotient/remainder) while done=1
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  localparam int CNT_W = $clog2(DATA_W);

  // hi_q is the partial product / partial remainder, lo_q the shifting
  // multiplier / dividend that fills up with quotient bits.
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] b_q;
  logic              div_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] lo_n;
  logic [DATA_W-1:0] hi_n;

  // Since the partial remainder stays below the divisor, the top bit of
  // diff is set exactly when the trial subtraction underflows.
  always_comb begin
    addend  = lo_q[0] ? b_q : '0;
    add_sum = {1'b0, hi_q} + {1'b0, addend};
    shifted = {hi_q, lo_q[DATA_W-1]};
    diff    = shifted - {1'b0, b_q};
    if (div_q) begin
      if (!diff[DATA_W]) begin
        hi_n = diff[DATA_W-1:0];
        lo_n = {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        hi_n = shifted[DATA_W-1:0];
        lo_n = {lo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_n = add_sum[DATA_W:1];
      lo_n = {add_sum[0], lo_q[DATA_W-1:1]};
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == CNT_W'(DATA_W - 1));
  assign lo   = lo_n;
  assign hi   = hi_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      lo_q   <= a;
      hi_q   <= '0;
      b_q    <= b;
      div_q  <= is_div;
      busy_q <= 1'b1;
      cnt    <= '0;
    end else if (busy_q) begin
      lo_q <= lo_n;
      hi_q <= hi_n;
      if (done) begin
        busy_q <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_control_md.sv
// alu_control_md
// MIPS ALU control decoder with a multi-cycle mult/div/mod unit.
// alu_sel is decoded combinationally from ALUOp/funct; mult, div and mod
// launch the iterative engine and hold the pipeline through stall until
// a one-cycle md_done pulse presents the registered result.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_in          instruction is live (not a bubble)
//   alu_op, func      ALUOp from main control, funct field
//   op_a, op_b        rs / rt operands
//   alu_sel           4-bit ALU select
//   stall             hold PC and pipeline registers
//   md_done           md_result/md_hi/div_by_zero valid this cycle
//   md_result, md_hi  mult lo/hi, div quotient/remainder, mod remainder/0
//   div_by_zero       div/mod had op_b == 0 (pulses with md_done)
// Build option: define ALU_CONTROL_MD_SIGNED_EN for two's-complement
// mult/div/mod (magnitudes into the engine, sign fix-up on completion).
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [3:0]        alu_sel,
  output logic              stall,
  output logic              md_done,
  output logic [DATA_W-1:0] md_result,
  output logic [DATA_W-1:0] md_hi,
  output logic              div_by_zero
);

  md_state_t state;
  md_state_t state_nxt;

  logic              is_md;
  logic              is_div_op;
  logic              is_mod_op;
  logic              b_zero;
  logic              eng_start;
  logic              launch_dbz;
  logic              eng_busy;
  logic              eng_done;
  logic [DATA_W-1:0] eng_lo;
  logic [DATA_W-1:0] eng_hi;
  logic [DATA_W-1:0] a_eng;
  logic [DATA_W-1:0] b_eng;
  logic              mod_q;

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   fin_lo;
  logic [DATA_W-1:0]   fin_hi;

  assign alu_sel   = decode_alu_sel(alu_op, func);
  assign is_md     = valid_in && is_md_sel(alu_sel);
  assign is_div_op = (alu_sel == ALU_DIV) || (alu_sel == ALU_MOD);
  assign is_mod_op = (alu_sel == ALU_MOD);
  assign b_zero    = (op_b == '0);

`ifdef ALU_CONTROL_MD_SIGNED_EN
  logic neg_a_q;
  logic neg_b_q;

  assign a_eng = op_a[DATA_W-1] ? -op_a : op_a;
  assign b_eng = op_b[DATA_W-1] ? -op_b : op_b;

  // Quotient/product sign is sign(a)^sign(b); the remainder follows a.
  // Most-negative / -1 falls out naturally: its magnitude quotient
  // negates back to the most-negative value with a zero remainder.
  always_comb begin
    prod = {eng_hi, eng_lo};
    quot = eng_lo;
    rem  = eng_hi;
    if (neg_a_q ^ neg_b_q) begin
      prod = -{eng_hi, eng_lo};
      quot = -eng_lo;
    end
    if (neg_a_q) begin
      rem = -eng_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (eng_start) begin
      neg_a_q <= op_a[DATA_W-1];
      neg_b_q <= op_b[DATA_W-1];
    end
  end
`else
  assign a_eng = op_a;
  assign b_eng = op_b;

  always_comb begin
    prod = {eng_hi, eng_lo};
    quot = eng_lo;
    rem  = eng_hi;
  end
`endif

  // Map the engine's final iteration onto the architectural outputs.
  always_comb begin
    if (state == MUL) begin
      fin_lo = prod[DATA_W-1:0];
      fin_hi = prod[2*DATA_W-1:DATA_W];
    end else if (mod_q) begin
      fin_lo = rem;
      fin_hi = '0;
    end else begin
      fin_lo = quot;
      fin_hi = rem;
    end
  end

  muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_engine (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .is_div (is_div_op),
    .a      (a_eng),
    .b      (b_eng),
    .busy   (eng_busy),
    .done   (eng_done),
    .lo     (eng_lo),
    .hi     (eng_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Divide-by-zero skips the engine entirely and goes straight to DONE.
  // DONE always returns to IDLE so the instruction that just completed
  // cannot relaunch while it is still on the inputs.
  always_comb begin
    state_nxt  = state;
    eng_start  = 1'b0;
    launch_dbz = 1'b0;
    case (state)
      IDLE: begin
        if (is_md) begin
          if (is_div_op && b_zero) begin
            launch_dbz = 1'b1;
            state_nxt  = DONE;
          end else begin
            eng_start = 1'b1;
            state_nxt = is_div_op ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        if (eng_done) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The engine is busy for exactly the MUL/DIV cycles, so stall is the
  // launch cycle plus the engine's busy window; reset forces it low even
  // while an md instruction sits on the inputs.
  assign stall   = rst_n && (((state == IDLE) && is_md) || eng_busy);
  assign md_done = (state == DONE);

  // Results are captured on entry to DONE and held until the next DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_result   <= '0;
      md_hi       <= '0;
      div_by_zero <= 1'b0;
      mod_q       <= 1'b0;
    end else begin
      if ((state == IDLE) && is_md) begin
        mod_q <= is_mod_op;
      end
      if (launch_dbz) begin
        md_result   <= is_mod_op ? op_a : '1;
        md_hi       <= is_mod_op ? '0 : op_a;
        div_by_zero <= 1'b1;
      end else if (eng_done) begin
        md_result   <= fin_lo;
        md_hi       <= fin_hi;
        div_by_zero <= 1'b0;
      end else if (state == DONE) begin
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md
// Self-checking bench for alu_control_md (DATA_W = 32). A transaction-level
// model (plain arithmetic plus a cycle countdown) predicts every output on
// every falling edge; directed sequences pin the model with literal values.
// Honours ALU_CONTROL_MD_SIGNED_EN the same way the design does.
module tb_alu_control_md;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [1:0]    alu_op;
  logic [5:0]    func;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [3:0]    alu_sel;
  logic          stall;
  logic          md_done;
  logic [DW-1:0] md_result;
  logic [DW-1:0] md_hi;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Model state: cycles left before the done pulse, and held results.
  int            run_left = 0;
  bit            done_now = 1'b0;
  logic [DW-1:0] held_res = '0;
  logic [DW-1:0] held_hi  = '0;
  bit            held_dbz = 1'b0;
  logic [DW-1:0] pend_res;
  logic [DW-1:0] pend_hi;
  bit            pend_dbz;
  logic [3:0]    exp_sel;
  bit            exp_md;
  bit            launching;

  alu_control_md #(
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .alu_op      (alu_op),
    .func        (func),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_sel     (alu_sel),
    .stall       (stall),
    .md_done     (md_done),
    .md_result   (md_result),
    .md_hi       (md_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic logic [3:0] refSel(logic [1:0] op, logic [5:0] f);
    if (op == 2'b01) return 4'd1;
    if (op != 2'b10) return 4'd0;
    case (f)
      6'd2:    return 4'd1;
      6'd8:    return 4'd2;
      6'd26:   return 4'd3;
      6'd4:    return 4'd4;
      6'd5:    return 4'd5;
      6'd6:    return 4'd6;
      6'd42:   return 4'd7;
      6'd7:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // Result of a whole md operation, straight from arithmetic.
  task automatic refMd(input logic [3:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output logic [DW-1:0] res, output logic [DW-1:0] hi, output bit dbz);
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    if (sel == 4'd2) begin
`ifdef ALU_CONTROL_MD_SIGNED_EN
      p = sa * sb;
`else
      p = {32'b0, a} * {32'b0, b};
`endif
      res = p[31:0];
      hi  = p[63:32];
    end else if (b == '0) begin
      dbz = 1'b1;
      res = (sel == 4'd8) ? a : 32'hFFFF_FFFF;
      hi  = (sel == 4'd8) ? 32'h0 : a;
    end else begin
`ifdef ALU_CONTROL_MD_SIGNED_EN
      q = sa / sb;
      r = sa % sb;
`else
      q = {32'b0, a / b};
      r = {32'b0, a % b};
`endif
      res = (sel == 4'd8) ? r[31:0] : q[31:0];
      hi  = (sel == 4'd8) ? 32'h0 : r[31:0];
    end
  endtask

  // Compare every cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (model_on) begin
      exp_sel = refSel(alu_op, func);
      checkOutput("alu_sel", alu_sel, exp_sel);
      if (!rst_n) begin
        run_left = 0;
        done_now = 1'b0;
        held_res = '0;
        held_hi  = '0;
        held_dbz = 1'b0;
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_md_done", md_done, 0);
        checkOutput("rst_dbz", div_by_zero, 0);
        checkOutput("rst_md_result", md_result, 0);
        checkOutput("rst_md_hi", md_hi, 0);
      end else begin
        exp_md = valid_in && (exp_sel == 4'd2 || exp_sel == 4'd3 || exp_sel == 4'd8);
        launching = exp_md && run_left == 0 && !done_now;
        checkOutput("stall", stall, launching || run_left != 0);
        checkOutput("md_done", md_done, done_now);
        checkOutput("div_by_zero", div_by_zero, done_now && held_dbz);
        checkOutput("md_result", md_result, held_res);
        checkOutput("md_hi", md_hi, held_hi);
        if (done_now) begin
          done_now = 1'b0;
        end else if (run_left > 0) begin
          run_left--;
          if (run_left == 0) begin
            done_now = 1'b1;
            held_res = pend_res;
            held_hi  = pend_hi;
            held_dbz = pend_dbz;
          end
        end else if (launching) begin
          refMd(exp_sel, op_a, op_b, pend_res, pend_hi, pend_dbz);
          if (pend_dbz) begin
            done_now = 1'b1;
            held_res = pend_res;
            held_hi  = pend_hi;
            held_dbz = pend_dbz;
          end else begin
            run_left = DW;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f,
                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk);
    #1;
    valid_in = v;
    alu_op   = op;
    func     = f;
    op_a     = a;
    op_b     = b;
  endtask

  // Inputs must already be applied; the next falling edge is cycle 0.
  task automatic waitMd(string name, int exp_stall, logic [DW-1:0] exp_res,
                        logic [DW-1:0] exp_hi, logic exp_dbz);
    int stalls;
    int n;
    stalls = 0;
    n = 0;
    @(negedge clk);
    while (md_done !== 1'b1 && n < 100) begin
      if (stall === 1'b1) stalls++;
      n++;
      @(negedge clk);
    end
    checkOutput({name, "_done"}, md_done, 1);
    checkOutput({name, "_stall_cycles"}, stalls, exp_stall);
    checkOutput({name, "_result"}, md_result, exp_res);
    checkOutput({name, "_hi"}, md_hi, exp_hi);
    checkOutput({name, "_dbz"}, div_by_zero, exp_dbz);
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
  endtask

  function automatic logic [DW-1:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return DW'($urandom_range(1, 15));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    logic [5:0] func_list [9];
    int r;
    func_list = '{6'd0, 6'd2, 6'd8, 6'd26, 6'd4, 6'd5, 6'd6, 6'd42, 6'd7};
    rst_n    = 1'b1;
    valid_in = 1'b0;
    alu_op   = 2'b00;
    func     = 6'd0;
    op_a     = '0;
    op_b     = '0;
    #2;
    rst_n    = 1'b0;
    model_on = 1'b1;
    @(negedge clk);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_md_result", md_result, 0);
    checkOutput("reset_md_hi", md_hi, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // slt never stalls or completes an md operation
    applyStimulus(1'b1, 2'b10, 6'd42, 32'd5, 32'd9);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("slt_sel", alu_sel, 7);
      checkOutput("slt_stall", stall, 0);
      checkOutput("slt_md_done", md_done, 0);
    end
    applyStimulus(1'b1, 2'b00, 6'd8, 32'd1, 32'd1);
    @(negedge clk);
    checkOutput("aluop00_sel", alu_sel, 0);
    checkOutput("aluop00_stall", stall, 0);
    applyStimulus(1'b1, 2'b01, 6'd26, 32'd1, 32'd1);
    @(negedge clk);
    checkOutput("aluop01_sel", alu_sel, 1);
    applyStimulus(1'b1, 2'b11, 6'd7, 32'd1, 32'd1);
    @(negedge clk);
    checkOutput("aluop11_sel", alu_sel, 0);
    checkOutput("aluop11_stall", stall, 0);
    applyStimulus(1'b1, 2'b10, 6'd63, 32'd1, 32'd1);
    @(negedge clk);
    checkOutput("func_unknown_sel", alu_sel, 0);

    applyStimulus(1'b1, 2'b10, 6'd8, 32'hFFFF_FFFF, 32'd2);
`ifdef ALU_CONTROL_MD_SIGNED_EN
    waitMd("mult_ones_x2", 33, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
`else
    waitMd("mult_ones_x2", 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`endif
    applyStimulus(1'b1, 2'b10, 6'd26, 32'd100, 32'd7);
    waitMd("div_100_7", 33, 32'd14, 32'd2, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'd7, 32'd100, 32'd7);
    waitMd("mod_100_7", 33, 32'd2, 32'd0, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'd26, 32'h55, 32'd0);
    waitMd("div_by_zero", 1, 32'hFFFF_FFFF, 32'h55, 1'b1);

    // reset in the middle of a mult, with the mult still on the inputs
    applyStimulus(1'b1, 2'b10, 6'd8, 32'h1234, 32'h5678);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_md_done", md_done, 0);
    checkOutput("midrst_md_result", md_result, 0);
    checkOutput("midrst_md_hi", md_hi, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd5;
    waitMd("mult_after_reset", 33, 32'd15, 32'd0, 1'b0);

`ifdef ALU_CONTROL_MD_SIGNED_EN
    applyStimulus(1'b1, 2'b10, 6'd26, 32'hFFFF_FFF9, 32'd2);
    waitMd("sdiv_m7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'd7, 32'hFFFF_FFF9, 32'd2);
    waitMd("smod_m7_2", 33, 32'hFFFF_FFFF, 32'h0, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'd8, 32'hFFFF_FFFD, 32'd5);
    waitMd("smult_m3_5", 33, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    waitMd("sdiv_min_m1", 33, 32'h8000_0000, 32'h0, 1'b0);
`else
    applyStimulus(1'b1, 2'b10, 6'd8, 32'h8000_0000, 32'h8000_0000);
    waitMd("mult_min_min", 33, 32'h0, 32'h4000_0000, 1'b0);
    applyStimulus(1'b1, 2'b10, 6'd7, 32'h66, 32'd0);
    waitMd("mod_by_zero", 1, 32'h66, 32'h0, 1'b1);
`endif

    // random traffic; inputs keep changing even while stalled
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      valid_in = ($urandom_range(0, 9) < 8);
      alu_op   = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom);
      r        = $urandom_range(0, 9);
      func     = (r < 9) ? func_list[r] : 6'($urandom);
      op_a     = randOperand();
      op_b     = randOperand();
    end
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
